// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters, plus mispredict/redirect generation.
// Optional gshare indexing is enabled by defining BP_GSHARE_EN.
module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int HIST_W  = 6,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc_f,
  output logic              pred_taken_f,
  output logic [ADDR_W-1:0] pred_target_f,
  output logic [IDX_W-1:0]  pred_idx_f,
  input  logic              upd_valid,
  input  logic              upd_cond,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              mispredict_m,
  output logic [ADDR_W-1:0] redirect_pc_m
);

  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(32'd1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_RST = CNT_WT - CNT_W'(32'd1);

  if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
    $error("ENTRIES must be a power of two >= 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be >= 1");
  end
  if (HIST_W < 1 || HIST_W > IDX_W) begin : g_bad_hist_w
    $error("HIST_W must be in 1..IDX_W");
  end

  logic              valid_r  [ENTRIES];
  logic [TAG_W-1:0]  tag_r    [ENTRIES];
  logic [ADDR_W-1:0] target_r [ENTRIES];
  logic [CNT_W-1:0]  cnt_r    [ENTRIES];

  logic [IDX_W-1:0]  look_idx_s;
  logic              look_hit_s;
  logic [ADDR_W-1:0] pc_plus4_s;

  logic              upd_hit_s;
  logic              upd_we_s;
  logic [CNT_W-1:0]  new_cnt_s;
  logic [ADDR_W-1:0] new_tgt_s;

`ifdef BP_GSHARE_EN
  logic [HIST_W-1:0] ghr_r;

  // Non-speculative global history, advanced only by resolved conditional branches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ghr_r <= '0;
    end else if (upd_valid && upd_cond) begin
      ghr_r <= HIST_W'({ghr_r, upd_taken});
    end
  end
`endif

  // Lookup index, hit detection and prediction.
  always_comb begin
    pc_plus4_s = pc_f + ADDR_W'(32'd4);
`ifdef BP_GSHARE_EN
    look_idx_s = pc_f[IDX_W+1:2] ^ IDX_W'(ghr_r);
`else
    look_idx_s = pc_f[IDX_W+1:2];
`endif
    look_hit_s = valid_r[look_idx_s] && (tag_r[look_idx_s] == pc_f[ADDR_W-1:IDX_W+2]);
    pred_idx_f = look_idx_s;
    if (look_hit_s && cnt_r[look_idx_s][CNT_W-1]) begin
      pred_taken_f  = 1'b1;
      pred_target_f = target_r[look_idx_s];
    end else begin
      pred_taken_f  = 1'b0;
      pred_target_f = pc_plus4_s;
    end
  end

  // Resolution check against the prediction carried down the pipe.
  always_comb begin
    mispredict_m  = 1'b0;
    redirect_pc_m = '0;
    if (upd_valid) begin
      mispredict_m = (upd_taken != upd_pred_taken) ||
                     (upd_taken && (upd_target != upd_pred_target));
      if (upd_taken) begin
        redirect_pc_m = upd_target;
      end else begin
        redirect_pc_m = upd_pc + ADDR_W'(32'd4);
      end
    end else begin
      mispredict_m  = 1'b0;
      redirect_pc_m = '0;
    end
  end

  // Training decision; the carried prediction deliberately plays no part here.
  always_comb begin
    upd_hit_s = valid_r[upd_idx] && (tag_r[upd_idx] == upd_pc[ADDR_W-1:IDX_W+2]);
    upd_we_s  = 1'b0;
    new_cnt_s = cnt_r[upd_idx];
    new_tgt_s = target_r[upd_idx];
    if (!upd_valid) begin
      upd_we_s = 1'b0;
    end else if (upd_hit_s) begin
      upd_we_s = 1'b1;
      if (!upd_cond) begin
        new_cnt_s = CNT_MAX;
      end else if (upd_taken) begin
        if (cnt_r[upd_idx] != CNT_MAX) begin
          new_cnt_s = cnt_r[upd_idx] + CNT_W'(32'd1);
        end else begin
          new_cnt_s = CNT_MAX;
        end
      end else begin
        if (cnt_r[upd_idx] != '0) begin
          new_cnt_s = cnt_r[upd_idx] - CNT_W'(32'd1);
        end else begin
          new_cnt_s = '0;
        end
      end
      if (upd_taken) begin
        new_tgt_s = upd_target;
      end else begin
        new_tgt_s = target_r[upd_idx];
      end
    end else if (upd_taken) begin
      upd_we_s  = 1'b1;
      new_tgt_s = upd_target;
      if (upd_cond) begin
        new_cnt_s = CNT_WT;
      end else begin
        new_cnt_s = CNT_MAX;
      end
    end else begin
      upd_we_s = 1'b0;
    end
  end

  // Entry storage; reset wipes everything including any update in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= '0;
        target_r[i] <= '0;
        cnt_r[i]    <= CNT_RST;
      end
    end else if (upd_we_s) begin
      valid_r[upd_idx]  <= 1'b1;
      tag_r[upd_idx]    <= upd_pc[ADDR_W-1:IDX_W+2];
      target_r[upd_idx] <= new_tgt_s;
      cnt_r[upd_idx]    <= new_cnt_s;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with a table-level reference model checked every cycle.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic [5:0]  pred_idx_f;
  logic        upd_valid;
  logic        upd_cond;
  logic [31:0] upd_pc;
  logic [5:0]  upd_idx;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict_m;
  logic [31:0] redirect_pc_m;

  int n_tests = 0;
  int n_fail  = 0;

  branch_predictor #(.ADDR_W(32), .ENTRIES(64), .CNT_W(2), .HIST_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .pc_f(pc_f),
    .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f), .pred_idx_f(pred_idx_f),
    .upd_valid(upd_valid), .upd_cond(upd_cond), .upd_pc(upd_pc), .upd_idx(upd_idx),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict_m(mispredict_m), .redirect_pc_m(redirect_pc_m)
  );

  always #5 clk = ~clk;

  // Reference model: a table of 64 entries holding plain integers.
  bit          m_valid [64];
  int unsigned m_tag   [64];
  bit [31:0]   m_tgt   [64];
  int          m_cnt   [64];
  int unsigned m_ghr = 0;

  function automatic int unsigned lidx(input bit [31:0] pc);
`ifdef BP_GSHARE_EN
    return ((pc >> 2) % 64) ^ m_ghr;
`else
    return (pc >> 2) % 64;
`endif
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) begin
        m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
      end
      m_ghr = 0;
    end else if (upd_valid) begin
      int unsigned i;
      bit hit;
      i   = upd_idx;
      hit = m_valid[i] && (m_tag[i] == (upd_pc >> 8));
      if (hit) begin
        if (!upd_cond) m_cnt[i] = 3;
        else if (upd_taken) m_cnt[i] = (m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1;
        else m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
        if (upd_taken) m_tgt[i] = upd_target;
      end else if (upd_taken) begin
        m_valid[i] = 1'b1; m_tag[i] = upd_pc >> 8; m_tgt[i] = upd_target;
        m_cnt[i] = upd_cond ? 2 : 3;
      end
      if (upd_cond) m_ghr = ((m_ghr << 1) | upd_taken) % 64;
    end
  end

  task automatic check(input string name, input bit [31:0] act, input bit [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int unsigned i;
    bit hit, e_taken, e_mis;
    bit [31:0] e_tgt, e_red;
    i       = lidx(pc_f);
    hit     = m_valid[i] && (m_tag[i] == (pc_f >> 8));
    e_taken = hit && (m_cnt[i] >= 2);
    e_tgt   = e_taken ? m_tgt[i] : pc_f + 32'd4;
    e_mis   = upd_valid && ((upd_taken != upd_pred_taken) ||
                            (upd_taken && (upd_target != upd_pred_target)));
    e_red   = !upd_valid ? 32'd0 : (upd_taken ? upd_target : upd_pc + 32'd4);
    check("model_pred_idx", {26'd0, pred_idx_f}, i);
    check("model_pred_taken", {31'd0, pred_taken_f}, {31'd0, e_taken});
    check("model_pred_target", pred_target_f, e_tgt);
    check("model_mispredict", {31'd0, mispredict_m}, {31'd0, e_mis});
    check("model_redirect", redirect_pc_m, e_red);
  end

  task automatic upd(input bit cond, input bit [31:0] pc, input bit taken, input bit [31:0] tgt,
                     input bit ptaken, input bit [31:0] ptgt);
    upd_valid = 1'b1; upd_cond = cond; upd_pc = pc; upd_idx = 6'(lidx(pc));
    upd_taken = taken; upd_target = tgt; upd_pred_taken = ptaken; upd_pred_target = ptgt;
  endtask

  task automatic idle();
    upd_valid = 1'b0; upd_cond = 1'b0; upd_pc = 32'd0; upd_idx = 6'd0;
    upd_taken = 1'b0; upd_target = 32'd0; upd_pred_taken = 1'b0; upd_pred_target = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    pc_f    = 32'h100;
    idle();
    #1;
    check("reset_taken", {31'd0, pred_taken_f}, 32'd0);
    check("reset_target", pred_target_f, 32'h104);
    check("reset_mispredict", {31'd0, mispredict_m}, 32'd0);
    tick(); tick();
    reset_n = 1'b1;

`ifdef BP_GSHARE_EN
    upd(1'b1, 32'h2000, 1'b1, 32'h3000, 1'b1, 32'h3000); tick();
    upd(1'b1, 32'h2000, 1'b1, 32'h3000, 1'b1, 32'h3000); tick();
    idle(); pc_f = 32'h100; #1;
    check("gshare_idx", {26'd0, pred_idx_f}, 32'h3);
    reset_n = 1'b0; #1; reset_n = 1'b1;
`endif

    // Training; same-cycle lookup still sees the old (empty) entry
    pc_f = 32'h100;
    upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104); #1;
    check("train_mispredict", {31'd0, mispredict_m}, 32'd1);
    check("train_redirect", redirect_pc_m, 32'h80);
    check("simul_old_state", {31'd0, pred_taken_f}, 32'd0);
    tick(); idle(); #1;
    check("train_taken", {31'd0, pred_taken_f}, 32'd1);
    check("train_target", pred_target_f, 32'h80);

    // Saturation: three more taken, then two not-taken
    repeat (3) begin upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80); tick(); end
    upd(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80); #1;
    check("sat_redirect", redirect_pc_m, 32'h104);
    tick(); idle(); #1;
    check("sat_still_taken", {31'd0, pred_taken_f}, 32'd1);
    upd(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80); tick(); idle(); #1;
    check("sat_now_not_taken", {31'd0, pred_taken_f}, 32'd0);
    check("sat_target", pred_target_f, 32'h104);

    // Aliasing 0x100 / 0x200
    upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104); tick(); idle();
    pc_f = 32'h200; #1;
    check("alias_miss", {31'd0, pred_taken_f}, 32'd0);
    check("alias_target", pred_target_f, 32'h204);
    upd(1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204); tick(); idle(); #1;
    check("alias_new_taken", pred_target_f, 32'h300);
    pc_f = 32'h100; #1;
    check("alias_old_miss", {31'd0, pred_taken_f}, 32'd0);

    // jal: allocate at max strength, then a wrong carried target
    pc_f = 32'h40;
    upd(1'b0, 32'h40, 1'b1, 32'h10, 1'b1, 32'h10); #1;
    check("jal_correct", {31'd0, mispredict_m}, 32'd0);
    tick(); idle(); #1;
    check("jal_target", pred_target_f, 32'h10);
    upd(1'b1, 32'h40, 1'b0, 32'h10, 1'b1, 32'h10); tick(); idle(); #1;
    check("jal_counter_max", {31'd0, pred_taken_f}, 32'd1);
    upd(1'b0, 32'h40, 1'b1, 32'h10, 1'b1, 32'h14); #1;
    check("jal_wrong_tgt", {31'd0, mispredict_m}, 32'd1);
    check("jal_redirect", redirect_pc_m, 32'h10);
    tick();

    // Not-taken miss allocates nothing
    upd(1'b1, 32'h500, 1'b0, 32'h900, 1'b0, 32'h504); #1;
    check("nt_redirect", redirect_pc_m, 32'h504);
    tick(); idle(); pc_f = 32'h500; #1;
    check("nt_no_alloc", {31'd0, pred_taken_f}, 32'd0);

    // Reset in the middle of a pending update
    upd(1'b1, 32'h600, 1'b1, 32'h700, 1'b0, 32'h604);
    pc_f = 32'h40;
    #2 reset_n = 1'b0; #1;
    check("rst_async_taken", {31'd0, pred_taken_f}, 32'd0);
    check("rst_async_target", pred_target_f, 32'h44);
    tick(); idle(); reset_n = 1'b1;
    pc_f = 32'h600; #1;
    check("rst_update_lost", {31'd0, pred_taken_f}, 32'd0);
    pc_f = 32'h200; #1;
    check("rst_cleared", {31'd0, pred_taken_f}, 32'd0);

    // Fall-through wraps modulo 2^32
    pc_f = 32'hFFFF_FFFC; #1;
    check("wrap_target", pred_target_f, 32'h0);

    // Mixed traffic over a few PCs, checked by the model every cycle
    for (int k = 0; k < 24; k++) begin
      bit [31:0] p;
      p = 32'h1000 + 32'(k % 5) * 32'd4 + 32'(k % 2) * 32'h400;
      pc_f = p;
      upd((k % 4) != 3, p, (k % 3) != 1, p + 32'h40, k[0], p + 32'h40);
      tick();
    end
    idle();
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
